// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS EX-stage ALU: funct/aluop codes, internal ALU control, FSM states.
// ALU_DIV_EN (optional define) enables div/divu decode; otherwise they decode as illegal.
package mips_alu_pkg;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_SLT   = 2'b11;

  typedef enum logic [3:0] {
    AC_ADD, AC_SUB, AC_AND, AC_OR, AC_XOR, AC_NOR, AC_SLT, AC_SLTU,
    AC_MFHI, AC_MFLO, AC_MULT, AC_MULTU, AC_DIV, AC_DIVU, AC_ILL
  } alu_ctrl_e;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} alu_state_e;

  function automatic alu_ctrl_e decode_ctrl(input logic [1:0] aluop, input logic [5:0] funct);
    alu_ctrl_e ctrl;
    ctrl = AC_ILL;
    case (aluop)
      OP_ADD: ctrl = AC_ADD;
      OP_SUB: ctrl = AC_SUB;
      OP_SLT: ctrl = AC_SLT;
      default: begin
        case (funct)
          F_ADD:   ctrl = AC_ADD;
          F_SUB:   ctrl = AC_SUB;
          F_AND:   ctrl = AC_AND;
          F_OR:    ctrl = AC_OR;
          F_XOR:   ctrl = AC_XOR;
          F_NOR:   ctrl = AC_NOR;
          F_SLT:   ctrl = AC_SLT;
          F_SLTU:  ctrl = AC_SLTU;
          F_MFHI:  ctrl = AC_MFHI;
          F_MFLO:  ctrl = AC_MFLO;
          F_MULT:  ctrl = AC_MULT;
          F_MULTU: ctrl = AC_MULTU;
`ifdef ALU_DIV_EN
          F_DIV:   ctrl = AC_DIV;
          F_DIVU:  ctrl = AC_DIVU;
`endif
          default: ctrl = AC_ILL;
        endcase
      end
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_exec_unit_mdu_iter.sv
// Iterative multiply (shift-add) / restoring divide datapath, one bit per cycle, with sign fix-up.
// ALU_DIV_EN (optional define) builds the divider path; otherwise multiply only.
module mdu_iter
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
`ifdef ALU_DIV_EN
  input  logic             is_div_i,
`endif
  input  logic             signed_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc, r_lo, r_mcand;
  logic               r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_mag_a = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_mag_b = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign w_sum   = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_mcand : '0)};
  assign last_o  = step_i && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset)       r_cnt <= '0;
    else if (load_i)  r_cnt <= '0;
    else if (step_i)  r_cnt <= r_cnt + 1'b1;
  end

`ifdef ALU_DIV_EN
  logic           r_is_div, r_div0;
  logic [WIDTH:0] w_rem_sh, w_diff;
  logic [WIDTH-1:0] w_q_fix, w_r_fix;

  assign w_rem_sh = {r_acc, r_lo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_mcand};
  assign w_q_fix  = r_div0 ? '1 : (r_neg_q ? -r_lo : r_lo);
  assign w_r_fix  = r_neg_r ? -r_acc : r_acc;

  always_ff @(posedge clk) begin
    if (load_i) begin
      r_is_div <= is_div_i;
      r_div0   <= is_div_i && (b_i == '0);
    end
  end
`endif

  // Operand latch and one iteration per step
  always_ff @(posedge clk) begin
    if (load_i) begin
      r_acc   <= '0;
      r_neg_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      r_neg_r <= signed_i && a_i[WIDTH-1];
`ifdef ALU_DIV_EN
      r_lo    <= is_div_i ? w_mag_a : w_mag_b;
      r_mcand <= is_div_i ? w_mag_b : w_mag_a;
`else
      r_lo    <= w_mag_b;
      r_mcand <= w_mag_a;
`endif
    end else if (step_i) begin
`ifdef ALU_DIV_EN
      if (r_is_div) begin
        r_acc <= w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_lo  <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
      end else begin
        r_acc <= w_sum[WIDTH:1];
        r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
`else
      r_acc <= w_sum[WIDTH:1];
      r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
`endif
    end
  end

  assign w_prod     = {r_acc, r_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

`ifdef ALU_DIV_EN
  assign hi_o = r_is_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign lo_o = r_is_div ? w_q_fix : w_prod_fix[WIDTH-1:0];
`else
  assign hi_o = w_prod_fix[2*WIDTH-1:WIDTH];
  assign lo_o = w_prod_fix[WIDTH-1:0];
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decode, single-cycle ALU with registered result, HI/LO and the mult/div FSM.
// ALU_DIV_EN (optional define) enables div/divu; without it they report illegal.
module alu_exec_unit
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [1:0]       aluop_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             illegal_o
);
  alu_ctrl_e         w_ctrl;
  alu_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_hi, r_lo, w_alu, w_mdu_hi, w_mdu_lo;
  logic              r_busy, w_accept, w_is_mul, w_is_div, w_mc, w_ill, w_last, w_step, w_signed;
  logic signed [WIDTH-1:0] w_a_s, w_b_s;

  assign w_ctrl   = decode_ctrl(aluop_i, funct_i);
  assign w_is_mul = (w_ctrl == AC_MULT) || (w_ctrl == AC_MULTU);
`ifdef ALU_DIV_EN
  assign w_is_div = (w_ctrl == AC_DIV) || (w_ctrl == AC_DIVU);
`else
  assign w_is_div = 1'b0;
`endif
  assign w_mc     = w_is_mul || w_is_div;
  assign w_signed = (w_ctrl == AC_MULT) || (w_ctrl == AC_DIV);
  assign w_accept = valid_i && !r_busy;
  assign w_step   = (r_state == MUL) || (r_state == DIV);
  assign w_a_s    = a_i;
  assign w_b_s    = b_i;
  assign busy_o   = r_busy;

  always_comb begin
    w_alu = '0;
    w_ill = 1'b0;
    case (w_ctrl)
      AC_ADD:  w_alu = a_i + b_i;
      AC_SUB:  w_alu = a_i - b_i;
      AC_AND:  w_alu = a_i & b_i;
      AC_OR:   w_alu = a_i | b_i;
      AC_XOR:  w_alu = a_i ^ b_i;
      AC_NOR:  w_alu = ~(a_i | b_i);
      AC_SLT:  w_alu = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      AC_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      AC_MFHI: w_alu = r_hi;
      AC_MFLO: w_alu = r_lo;
      AC_ILL:  w_ill = 1'b1;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul) w_state_nxt = MUL;
`ifdef ALU_DIV_EN
        else if (w_accept && w_is_div) w_state_nxt = DIV;
`endif
      end
      MUL, DIV: if (w_last) w_state_nxt = FIX;
      FIX:      w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .load_i   (w_accept && w_mc),
`ifdef ALU_DIV_EN
    .is_div_i (w_is_div),
`endif
    .signed_i (w_signed),
    .step_i   (w_step),
    .a_i      (a_i),
    .b_i      (b_i),
    .last_o   (w_last),
    .hi_o     (w_mdu_hi),
    .lo_o     (w_mdu_lo)
  );

  // Output stage: busy stays high through the FIX write so it drops one cycle after valid_o
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_o  <= '0;
      zero_o    <= 1'b0;
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
      r_busy    <= (w_accept && w_mc) || (r_state != IDLE);
      if (r_state == FIX) begin
        r_hi     <= w_mdu_hi;
        r_lo     <= w_mdu_lo;
        result_o <= w_mdu_lo;
        zero_o   <= (w_mdu_lo == '0);
        valid_o  <= 1'b1;
      end else if (w_accept && !w_mc) begin
        result_o  <= w_alu;
        zero_o    <= (w_alu == '0);
        valid_o   <= 1'b1;
        illegal_o <= w_ill;
      end
    end
  end

endmodule
